// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and stage-timer width for rst_seq
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_REL_USB = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam int TIMER_W = 16;

endpackage

// File: rtl/rst_seq_if.sv
// rtl/rst_seq_if.sv - reset/time-base bundle between the sequencer and its consumers
interface rst_seq_if;

  logic soft_rst_req;
  logic rst_usb;
  logic rst_app;
  logic ready;
  logic tick_us;
  logic tick_ms;

  // master is the sequencer itself; slave is whoever consumes resets and strobes
  modport master (
    input  soft_rst_req,
    output rst_usb,
    output rst_app,
    output ready,
    output tick_us,
    output tick_ms
  );

  modport slave (
    output soft_rst_req,
    input  rst_usb,
    input  rst_app,
    input  ready,
    input  tick_us,
    input  tick_ms
  );

endinterface

// File: rtl/rst_seq_tick_gen.sv
// rtl/rst_seq_tick_gen.sv - free-running prescaler producing 1 us and 1 ms strobes
module rst_seq_tick_gen #(
  parameter int DIV_US    = 48,
  parameter int US_PER_MS = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_us,
  output logic tick_ms,
  output logic tick_next
);

  localparam int PW = $clog2(DIV_US);
  localparam int MW = $clog2(US_PER_MS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_US - 1);
  localparam logic [MW-1:0] MS_MAX    = MW'(US_PER_MS - 1);

  logic [PW-1:0] presc;
  logic [MW-1:0] ms_cnt;

  // tick_next marks the edge on which tick_us will be registered high, so the
  // sequencer can act on the same edge the strobe appears
  assign tick_next = (presc == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      ms_cnt  <= '0;
      tick_us <= 1'b0;
      tick_ms <= 1'b0;
    end else begin
      tick_us <= tick_next;
      tick_ms <= tick_next && (ms_cnt == MS_MAX);
      if (tick_next) begin
        presc  <= '0;
        ms_cnt <= (ms_cnt == MS_MAX) ? '0 : ms_cnt + MW'(1);
      end else begin
        presc  <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staged USB/application reset release with soft-reset re-run
module rst_seq #(
  parameter int DIV_US    = 48,
  parameter int US_PER_MS = 1000,
  parameter int HOLD_US   = 100,
  parameter int STAGE_US  = 10
) (
  input  logic     clk,
  input  logic     rst,
  rst_seq_if.master bus
);

  import rst_seq_pkg::*;

  localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_US - 1);
  localparam logic [TIMER_W-1:0] STAGE_LAST = TIMER_W'(STAGE_US - 1);

  state_t             state;
  state_t             state_next;
  logic [TIMER_W-1:0] stage_timer;
  logic [TIMER_W-1:0] timer_next;
  logic               tick_next;
  logic               tick_us_q;
  logic               tick_ms_q;
  logic               rst_usb_q;
  logic               rst_app_q;
  logic               ready_q;

  rst_seq_tick_gen #(
    .DIV_US    (DIV_US),
    .US_PER_MS (US_PER_MS)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .tick_us   (tick_us_q),
    .tick_ms   (tick_ms_q),
    .tick_next (tick_next)
  );

  always_comb begin
    state_next = state;
    timer_next = tick_next ? stage_timer + TIMER_W'(1) : stage_timer;

    if (bus.soft_rst_req) begin
      state_next = ST_HOLD;
    end else begin
      case (state)
        ST_HOLD:    if (tick_next && stage_timer == HOLD_LAST)  state_next = ST_REL_USB;
        ST_REL_USB: if (tick_next && stage_timer == STAGE_LAST) state_next = ST_RUN;
        ST_RUN:     state_next = ST_RUN;
        default:    state_next = ST_HOLD;
      endcase
    end

    // a request in HOLD is not a state change but still restarts the hold
    if (bus.soft_rst_req || state_next != state) begin
      timer_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HOLD;
      stage_timer <= '0;
      rst_usb_q   <= 1'b1;
      rst_app_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state       <= state_next;
      stage_timer <= timer_next;
      rst_usb_q   <= (state_next == ST_HOLD);
      rst_app_q   <= (state_next != ST_RUN);
      ready_q     <= (state_next == ST_RUN);
    end
  end

  assign bus.rst_usb = rst_usb_q;
  assign bus.rst_app = rst_app_q;
  assign bus.ready   = ready_q;
  assign bus.tick_us = tick_us_q;
  assign bus.tick_ms = tick_ms_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - directed bench for rst_seq with DIV_US=4, US_PER_MS=5, HOLD_US=3, STAGE_US=2
module tb_rst_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k = 0;
  int   checks = 0;
  int   errors = 0;

  rst_seq_if bus();

  rst_seq #(
    .DIV_US    (4),
    .US_PER_MS (5),
    .HOLD_US   (3),
    .STAGE_US  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.rst_usb, bus.rst_app, bus.ready, bus.tick_us, bus.tick_ms};
  endfunction

  // {rst_usb, rst_app, ready, tick_us, tick_ms} expected after edge k, given the
  // edges at which rst_usb and rst_app are due to fall; ticks fall every 4 edges, ms every 20
  task automatic check_span(input int k_to, input int usb_rel, input int app_rel, input bit req_first);
    logic [4:0] exp;
    bit first;
    first = req_first;
    while (k < k_to) begin
      bus.soft_rst_req = first;
      step();
      bus.soft_rst_req = 1'b0;
      first = 1'b0;
      exp = {k < usb_rel, k < app_rel, k >= app_rel, (k % 4) == 0, (k % 20) == 0};
      check("outputs", 16'(outs()), 16'(exp));
    end
  endtask

  initial begin
    bus.soft_rst_req = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("reset_outputs", 16'(outs()), 16'(5'b11000));

    for (int i = 0; i < 10; i++) begin
      bus.soft_rst_req = ~bus.soft_rst_req;
      step();
      check("rst_hold_outputs", 16'(outs()), 16'(5'b11000));
      check("rst_hold_presc", 16'(dut.u_tick.presc), 16'd0);
    end
    bus.soft_rst_req = 1'b0;

    rst = 1'b0;
    k = 0;
    check_span(24, 12, 20, 1'b0);
    check_span(26, 12, 20, 1'b0);

    check_span(49, 36, 44, 1'b1);

    check_span(63, 60, 68, 1'b1);
    check_span(64, 76, 84, 1'b1);
    check("timer_after_req_tick", dut.stage_timer, 16'd0);
    check_span(91, 76, 84, 1'b0);

    for (int r = 0; r < 6; r++) begin
      check_span(97 + 6 * r, 9999, 9999, 1'b1);
    end
    check_span(142, 140, 148, 1'b1);

    rst = 1'b1;
    step();
    check("mid_rst_outputs", 16'(outs()), 16'(5'b11000));
    check("mid_rst_presc", 16'(dut.u_tick.presc), 16'd0);
    check("mid_rst_timer", dut.stage_timer, 16'd0);
    rst = 1'b0;
    k = 0;
    check_span(24, 12, 20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Staged reset sequencer and time-base generator for the 48 MHz system domain. It takes the global reset from the clock/reset manager and releases the USB core and then the application logic in a fixed order, with programmable hold times. It also supplies free-running 1 µs and 1 ms strobes to the rest of the design, and re-runs the sequence on a software reset request.

## Interface
- `DIV_US`, default 48: clock cycles per µs tick (≥2).
- `US_PER_MS`, default 1000: µs ticks per ms tick (≥2).
- `HOLD_US`, default 100: µs with all resets asserted before the USB core is released (1..65535).
- `STAGE_US`, default 10: µs between USB core release and application release (1..65535).

- `clk`  in  1  system clock, 48 MHz. The block uses this one clock only.
- `rst`  in  1  reset, synchronous, active-high. Driven by the global reset buffer.
- `soft_rst_req`  in  1  single-cycle request to re-run the reset sequence.
- `rst_usb`  out  1  USB core reset, active-high, registered.
- `rst_app`  out  1  application reset, active-high, registered.
- `ready`  out  1  high when both resets are released, registered.
- `tick_us`  out  1  one-cycle strobe every `DIV_US` cycles.
- `tick_ms`  out  1  one-cycle strobe every `US_PER_MS` µs ticks.

## Operation
- Values while `rst`=1 and after it:
  - `rst_usb`=1, `rst_app`=1, `ready`=0, `tick_us`=0, `tick_ms`=0.
  - Prescaler, ms counter and stage timer are 0; state is HOLD.
- Prescaler:
  - Width is $clog2(`DIV_US`); it counts 0..`DIV_US`-1 and wraps.
  - `tick_us` is registered high on the edge where the prescaler wraps.
- ms counter:
  - Width is $clog2(`US_PER_MS`); it advances on `tick_us` and wraps at `US_PER_MS`-1.
  - `tick_ms` is asserted in the same cycle as the `tick_us` that causes the wrap.
- Both strobes are free-running and are never affected by `soft_rst_req`.
- Stage timer: 16 bits, increments on `tick_us`, cleared on every state change.
- FSM states and transitions:
  - HOLD: `rst_usb`=1, `rst_app`=1, `ready`=0. When the timer would reach `HOLD_US` (a tick arrives with timer=`HOLD_US`-1), go to REL_USB.
  - REL_USB: `rst_usb`=0, `rst_app`=1. When the timer would reach `STAGE_US`, go to RUN.
  - RUN: `rst_usb`=0, `rst_app`=0, `ready`=1. Stays here until a request.
- All outputs are registered from the next-state logic, so each output changes on the same edge as the state transition.
- `soft_rst_req`=1 in any state:
  - Next state is HOLD, timer is cleared, and `rst_usb`/`rst_app`=1, `ready`=0 on the next edge.
  - A request while already in HOLD restarts the hold period.
- Request and `tick_us` in the same cycle: the request wins and the timer is 0 afterwards.
- `rst` has priority over everything, including a request.

## Timing
- Count edges k=1,2,… from the first edge where `rst` is sampled 0.
- `tick_us` is high after edges k = n·`DIV_US`.
- `rst_usb` falls after edge `HOLD_US`·`DIV_US`.
- `rst_app` falls and `ready` rises after edge (`HOLD_US`+`STAGE_US`)·`DIV_US`.
- Soft-reset latency: 1 cycle from the sampled request to the resets asserting.
- After a soft reset the prescaler phase is arbitrary, so the hold lasts between (`HOLD_US`-1)·`DIV_US`+1 and `HOLD_US`·`DIV_US` cycles. The stage time is exact, since it starts on a tick.
- No combinational path from any input to any output.

## Structure
- Shared package: state encoding (HOLD=0, REL_USB=1, RUN=2) and the 16-bit stage-timer width constant.
- Natural sub-module: `tick_gen`, holding the prescaler and ms counter that produce `tick_us`/`tick_ms`. `rst_seq` keeps the FSM and the stage timer.

## Test plan
All scenarios use `DIV_US`=4, `US_PER_MS`=5, `HOLD_US`=3, `STAGE_US`=2.
- Power-up: release `rst` → `tick_us` after edges 4,8,12…; `tick_ms` after edge 20; `rst_usb` falls after edge 12; `rst_app` falls and `ready` rises after edge 20.
- Reset check: hold `rst`=1 for 10 cycles with `soft_rst_req` toggling → all outputs stay at their reset values and the prescaler stays at 0.
- Soft reset in RUN: pulse the request 3 cycles after a tick → after 1 cycle `rst_usb`=`rst_app`=1 and `ready`=0; `rst_usb` falls 9 cycles after the pulse; the ticks keep their original period and phase.
- Request in REL_USB coincident with a tick → HOLD, timer=0, and a full hold measured from the next tick.
- Repeated requests every 6 cycles for 40 cycles → `rst_usb` stays high throughout; release follows the last request per the hold bound.
- Mid-sequence `rst` (during REL_USB) → next edge gives all reset values; the sequence timing after release is identical to power-up.
